// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter letting two cores share one synchronous memory port.
// One access at a time: IDLE grants, ACCESS drives the memory, RESP acks the owner.
module shared_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] a1,
   input  logic [DATA_W-1:0] wd1,
   output logic [DATA_W-1:0] rd1,
   output logic              ack1,
   output logic              stall1,
   input  logic              req2,
   input  logic              we2,
   input  logic [ADDR_W-1:0] a2,
   input  logic [DATA_W-1:0] wd2,
   output logic [DATA_W-1:0] rd2,
   output logic              ack2,
   output logic              stall2,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q;
   logic                owner_q;   // 0: core 1, 1: core 2
   logic                last_q;    // core that received the most recent grant
   logic                we_q;
   logic                ack1_q;
   logic                ack2_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_a_q;
   logic [DATA_W-1:0]   mem_wd_q;
   logic [DATA_W-1:0]   rd1_q;
   logic [DATA_W-1:0]   rd2_q;
   logic                grant2;
   logic                rd_live;

   // Core 2 wins when alone, or on a tie when core 1 was served last.
   always_comb grant2 = req2 & (~req1 | ~last_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         we_q     <= 1'b0;
         ack1_q   <= 1'b0;
         ack2_q   <= 1'b0;
         mem_we_q <= 1'b0;
         mem_a_q  <= '0;
         mem_wd_q <= '0;
         rd1_q    <= '0;
         rd2_q    <= '0;
      end else begin
         ack1_q   <= 1'b0;
         ack2_q   <= 1'b0;
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req1 | req2) begin
                  owner_q  <= grant2;
                  last_q   <= grant2;
                  we_q     <= grant2 ? we2 : we1;
                  mem_we_q <= grant2 ? we2 : we1;
                  mem_a_q  <= grant2 ? a2  : a1;
                  mem_wd_q <= grant2 ? wd2 : wd1;
                  state_q  <= ACCESS;
               end
            end
            ACCESS: begin
               ack1_q  <= ~owner_q;
               ack2_q  <= owner_q;
               state_q <= RESP;
            end
            RESP: begin
               if (!we_q) begin
                  if (owner_q) rd2_q <= mem_rd;
                  else         rd1_q <= mem_rd;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Read data bypasses the holding register during RESP so it is valid in the ack cycle.
   always_comb rd_live = (state_q == RESP) && !we_q;

   assign rd1    = (rd_live && !owner_q) ? mem_rd : rd1_q;
   assign rd2    = (rd_live &&  owner_q) ? mem_rd : rd2_q;
   assign ack1   = ack1_q;
   assign ack2   = ack2_q;
   assign stall1 = req1 & ~ack1_q;
   assign stall2 = req2 & ~ack2_q;
   assign mem_we = mem_we_q;
   assign mem_a  = mem_a_q;
   assign mem_wd = mem_wd_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter: directed requests push expected acks and
// memory writes; a negedge monitor pops and compares whenever ack or mem_we appears.
module tb_shared_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req1 = 1'b0, we1 = 1'b0, req2 = 1'b0, we2 = 1'b0;
   logic [31:0] a1 = '0, wd1 = '0, a2 = '0, wd2 = '0;
   logic [31:0] rd1, rd2, mem_a, mem_wd;
   logic [31:0] mem_rd = '0;
   logic        ack1, ack2, stall1, stall2, mem_we;

   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct { int unsigned cyc; logic [31:0] rd; } ack_t;
   typedef struct { int unsigned cyc; logic [31:0] a; logic [31:0] wd; } wr_t;
   ack_t q1[$];
   ack_t q2[$];
   wr_t  wq[$];

   logic [31:0] mem [0:255];
   logic        mem_init = 1'b0;

   shared_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .req1(req1), .we1(we1), .a1(a1), .wd1(wd1), .rd1(rd1), .ack1(ack1), .stall1(stall1),
      .req2(req2), .we2(we2), .a2(a2), .wd2(wd2), .rd2(rd2), .ack2(ack2), .stall2(stall2),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous memory, word index a[9:2]; preloaded with 0xA00000xx on the first edge.
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
         mem_init <= 1'b1;
      end else begin
         if (mem_we) mem[mem_a[9:2]] <= mem_wd;
         mem_rd <= mem[mem_a[9:2]];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      ack_t e;
      wr_t  w;
      if (ack1) begin
         if (q1.size() == 0) check("unexpected_ack1", 32'd1, 32'd0);
         else begin
            e = q1.pop_front();
            check("ack1_cycle", cyc, e.cyc);
            check("rd1_at_ack", rd1, e.rd);
         end
      end
      if (ack2) begin
         if (q2.size() == 0) check("unexpected_ack2", 32'd1, 32'd0);
         else begin
            e = q2.pop_front();
            check("ack2_cycle", cyc, e.cyc);
            check("rd2_at_ack", rd2, e.rd);
         end
      end
      if (mem_we) begin
         if (wq.size() == 0) check("unexpected_mem_we", 32'd1, 32'd0);
         else begin
            w = wq.pop_front();
            check("mem_we_cycle", cyc, w.cyc);
            check("mem_a", mem_a, w.a);
            check("mem_wd", mem_wd, w.wd);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req1 = 1'b0;
      req2 = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic single(input int core, input logic we, input logic [31:0] ad,
                         input logic [31:0] d, input logic [31:0] exp_rd);
      int unsigned c;
      ack_t e;
      wr_t  w;
      c = cyc;
      e.cyc = c + 2;
      e.rd  = exp_rd;
      if (core == 1) begin
         req1 = 1'b1; we1 = we; a1 = ad; wd1 = d;
         q1.push_back(e);
      end else begin
         req2 = 1'b1; we2 = we; a2 = ad; wd2 = d;
         q2.push_back(e);
      end
      if (we) begin
         w.cyc = c + 1; w.a = ad; w.wd = d;
         wq.push_back(w);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check(core == 1 ? "stall1_single" : "stall2_single",
               {31'd0, (core == 1) ? stall1 : stall2}, {31'd0, k < 2});
         tick();
      end
      if (core == 1) req1 = 1'b0;
      else           req2 = 1'b0;
   endtask

   task automatic pair(input logic [31:0] ad1, input logic [31:0] e1,
                       input logic [31:0] ad2, input logic [31:0] e2);
      int unsigned c;
      ack_t e;
      c = cyc;
      req1 = 1'b1; we1 = 1'b0; a1 = ad1;
      req2 = 1'b1; we2 = 1'b0; a2 = ad2;
      e.cyc = c + 2; e.rd = e1; q1.push_back(e);
      e.cyc = c + 5; e.rd = e2; q2.push_back(e);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("stall2_pair", {31'd0, stall2}, {31'd0, k < 5});
         if (k <= 2) check("stall1_pair", {31'd0, stall1}, {31'd0, k < 2});
         tick();
         if (k == 2) req1 = 1'b0;
      end
      req2 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned c;
      ack_t e;
      wr_t  w;

      do_reset();
      @(negedge clk);
      check("rst_ack1", {31'd0, ack1}, 32'd0);
      check("rst_ack2", {31'd0, ack2}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_a", mem_a, 32'd0);
      check("rst_mem_wd", mem_wd, 32'd0);
      check("rst_rd1", rd1, 32'd0);
      check("rst_rd2", rd2, 32'd0);
      tick();

      // Write then read back through core 1; core 2 reads the same word.
      single(1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0);
      check("rd1_after_write", rd1, 32'h0);
      single(1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
      single(2, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
      check("rd1_hold", rd1, 32'hDEADBEEF);

      // Simultaneous first requests after reset: core 1 first.
      do_reset();
      pair(32'h44, 32'hA000_0011, 32'h80, 32'hA000_0020);
      check("rd1_hold_pair", rd1, 32'hA000_0011);

      // Both held for 12 cycles: grants alternate 1,2,1,2.
      c = cyc;
      req1 = 1'b1; we1 = 1'b0; a1 = 32'h48;
      req2 = 1'b1; we2 = 1'b0; a2 = 32'h88;
      e.rd = 32'hA000_0012; e.cyc = c + 2;  q1.push_back(e);
      e.cyc = c + 8;  q1.push_back(e);
      e.rd = 32'hA000_0022; e.cyc = c + 5;  q2.push_back(e);
      e.cyc = c + 11; q2.push_back(e);
      for (int k = 0; k < 12; k++) tick();
      req1 = 1'b0;
      req2 = 1'b0;

      // Reset hits the ACCESS cycle of a core 2 write.
      c = cyc;
      req2 = 1'b1; we2 = 1'b1; a2 = 32'h8C; wd2 = 32'h1234_5678;
      w.cyc = c + 1; w.a = 32'h8C; w.wd = 32'h1234_5678; wq.push_back(w);
      tick();
      reset = 1'b1;
      req2 = 1'b0;
      we2 = 1'b0;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("midrst_ack2", {31'd0, ack2}, 32'd0);
      check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
      check("midrst_rd2", rd2, 32'd0);
      tick();
      pair(32'h8C, 32'h1234_5678, 32'h4C, 32'hA000_0013);

      // Core 2 drops its request right after capture.
      c = cyc;
      req2 = 1'b1; we2 = 1'b0; a2 = 32'h84;
      e.cyc = c + 2; e.rd = 32'hA000_0021; q2.push_back(e);
      tick();
      req2 = 1'b0;
      @(negedge clk);
      check("stall2_dropped", {31'd0, stall2}, 32'd0);
      for (int k = 0; k < 6; k++) tick();
      check("rd2_after_drop", rd2, 32'hA000_0021);

      check("q1_drained", q1.size(), 32'd0);
      check("q2_drained", q2.size(), 32'd0);
      check("wq_drained", wq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
